// File: rtl/mycpu_pkg.sv
// mycpu_pkg
// CPU-wide shared types and default sizing for the instruction path.
//   IR_WIDTH_DEF : default instruction word width (bits)
//   IR_DEPTH_DEF : default instruction queue depth (entries)
//   ins_t        : CPU-wide instruction word type
package mycpu_pkg;

   localparam int IR_WIDTH_DEF = 16;
   localparam int IR_DEPTH_DEF = 4;

   typedef logic [15:0] ins_t;

endpackage : mycpu_pkg

// File: rtl/ir_ptr.sv
// ir_ptr
// Wrap-around pointer counter for the instruction queue. DEPTH is a power of
// two, so the pointer wraps DEPTH-1 -> 0 by natural overflow.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, pointer -> 0
//   inc   : advance the pointer by one
//   clr   : synchronous clear to 0, wins over inc
//   ptr   : current pointer value
module ir_ptr
   import mycpu_pkg::*;
#(
   parameter int DEPTH = IR_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       inc,
   input  logic                       clr,
   output logic [$clog2(DEPTH)-1:0]   ptr
);

   localparam int PW = $clog2(DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + PW'(1);
      end
   end

endmodule : ir_ptr

// File: rtl/ir_queue.sv
// ir_queue
// Instruction register queue between fetch and decode. Buffers up to DEPTH
// fetched words in FIFO order and presents the oldest one to decode. When the
// queue is empty the last consumed word is held on ins_out, so the block still
// behaves like a classic single-entry IR from the decoder's point of view.
// DEPTH must be a power of two and at least 2.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   il_in    : load strobe, push ins_in when accepted
//   ins_in   : instruction word from fetch
//   rdy_out  : a push can be accepted this cycle (combinational from adv_in)
//   adv_in   : decode consumes the head word
//   flush_in : discard all queued words; overrides il_in/adv_in
//   vld_out  : ins_out is a queued, unconsumed word
//   ins_out  : head word when vld_out, else last consumed word
//   cnt_out  : number of queued words
module ir_queue
   import mycpu_pkg::*;
#(
   parameter int WIDTH = IR_WIDTH_DEF,
   parameter int DEPTH = IR_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        il_in,
   input  logic [WIDTH-1:0]            ins_in,
   output logic                        rdy_out,
   input  logic                        adv_in,
   input  logic                        flush_in,
   output logic                        vld_out,
   output logic [WIDTH-1:0]            ins_out,
   output logic [$clog2(DEPTH+1)-1:0]  cnt_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] last_r;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   logic not_full;
   logic not_empty;
   logic pop_ok;
   logic push_ok;
   logic pop;
   logic push;

   assign not_full  = (count_r < CW'(DEPTH));
   assign not_empty = (count_r != '0);

   // A pop in the same cycle frees the slot, so a full queue still accepts
   // a push alongside a pop. This is what gives 1-in/1-out per cycle when full.
   assign pop_ok  = adv_in & not_empty;
   assign push_ok = il_in & (not_full | pop_ok);

   // Flush wins over both; rdy_out is deliberately not gated by flush_in.
   assign pop  = pop_ok  & ~flush_in;
   assign push = push_ok & ~flush_in;

   assign rdy_out = not_full | pop_ok;
   assign vld_out = not_empty;
   assign cnt_out = count_r;
   assign ins_out = not_empty ? mem[rd_ptr] : last_r;

   ir_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop),
      .clr   (flush_in),
      .ptr   (rd_ptr)
   );

   ir_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .clr   (flush_in),
      .ptr   (wr_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (flush_in) begin
         count_r <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // last_r is untouched by flush so the decoder keeps seeing the last
   // consumed word after a taken branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= '0;
      end else if (pop) begin
         last_r <= mem[rd_ptr];
      end
   end

   // Storage contents are never observed while invalid, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= ins_in;
      end
   end

endmodule : ir_queue

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

   logic clk;
   logic rst_n;

   logic        il_v    [3];
   logic        adv_v   [3];
   logic        flush_v [3];
   logic [31:0] din_v   [3];
   logic [31:0] ins_o   [3];
   logic [3:0]  cnt_o   [3];
   logic        vld_o   [3];
   logic        rdy_o   [3];

   logic [15:0] ins0;
   logic [7:0]  ins1;
   logic [31:0] ins2;
   logic [2:0]  cnt0;
   logic [1:0]  cnt1;
   logic [3:0]  cnt2;

   int n_checks;
   int n_errors;

   ir_queue #(.WIDTH(16), .DEPTH(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .il_in(il_v[0]), .ins_in(din_v[0][15:0]),
      .rdy_out(rdy_o[0]), .adv_in(adv_v[0]), .flush_in(flush_v[0]),
      .vld_out(vld_o[0]), .ins_out(ins0), .cnt_out(cnt0));

   ir_queue #(.WIDTH(8), .DEPTH(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .il_in(il_v[1]), .ins_in(din_v[1][7:0]),
      .rdy_out(rdy_o[1]), .adv_in(adv_v[1]), .flush_in(flush_v[1]),
      .vld_out(vld_o[1]), .ins_out(ins1), .cnt_out(cnt1));

   ir_queue #(.WIDTH(32), .DEPTH(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .il_in(il_v[2]), .ins_in(din_v[2]),
      .rdy_out(rdy_o[2]), .adv_in(adv_v[2]), .flush_in(flush_v[2]),
      .vld_out(vld_o[2]), .ins_out(ins2), .cnt_out(cnt2));

   assign ins_o[0] = {16'd0, ins0};
   assign ins_o[1] = {24'd0, ins1};
   assign ins_o[2] = ins2;
   assign cnt_o[0] = {1'b0, cnt0};
   assign cnt_o[1] = {2'b0, cnt1};
   assign cnt_o[2] = cnt2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   // One clock on queue k with the given inputs, then inputs return to idle.
   task automatic step(input int k, input logic il, input logic adv, input logic fl,
                       input logic [31:0] d);
      @(negedge clk);
      il_v[k] = il; adv_v[k] = adv; flush_v[k] = fl; din_v[k] = d;
      @(posedge clk);
      #1;
      il_v[k] = 1'b0; adv_v[k] = 1'b0; flush_v[k] = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (vld_o[0] !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b want 0", vld_o[0]); end
      n_checks++; if (cnt_o[0] !== 4'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_o[0]); end
      n_checks++; if (ins_o[0] !== 32'h0) begin n_errors++; $display("FAIL reset_ins: got %h want 0000", ins_o[0]); end
      n_checks++; if (rdy_o[0] !== 1'b1) begin n_errors++; $display("FAIL reset_rdy: got %b want 1", rdy_o[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1'b1, 1'b0, 1'b0, 32'h1111);
      step(0, 1'b1, 1'b0, 1'b0, 32'h2222);
      n_checks++; if (cnt_o[0] !== 4'd2) begin n_errors++; $display("FAIL pre_reset_cnt: got %0d want 2", cnt_o[0]); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (vld_o[0] !== 1'b0) begin n_errors++; $display("FAIL midrst_vld: got %b want 0", vld_o[0]); end
      n_checks++; if (cnt_o[0] !== 4'd0) begin n_errors++; $display("FAIL midrst_cnt: got %0d want 0", cnt_o[0]); end
      n_checks++; if (ins_o[0] !== 32'h0) begin n_errors++; $display("FAIL midrst_ins: got %h want 0000", ins_o[0]); end
      n_checks++; if (rdy_o[0] !== 1'b1) begin n_errors++; $display("FAIL midrst_rdy: got %b want 1", rdy_o[0]); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fifo_order();
      logic [31:0] exp_head [3];
      exp_head[0] = 32'hA001; exp_head[1] = 32'hA002; exp_head[2] = 32'hA003;
      for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, exp_head[i]);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (ins_o[0] !== exp_head[i] || vld_o[0] !== 1'b1) begin
            n_errors++; $display("FAIL fifo_head%0d: got %h/%b want %h/1", i, ins_o[0], vld_o[0], exp_head[i]);
         end
         step(0, 1'b0, 1'b1, 1'b0, 32'h0);
      end
      n_checks++; if (vld_o[0] !== 1'b0 || ins_o[0] !== 32'hA003) begin
         n_errors++; $display("FAIL fifo_hold: got %h/%b want a003/0", ins_o[0], vld_o[0]);
      end
      step(0, 1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++; if (ins_o[0] !== 32'hA003 || cnt_o[0] !== 4'd0) begin
         n_errors++; $display("FAIL fifo_adv_empty: got %h cnt %0d want a003 cnt 0", ins_o[0], cnt_o[0]);
      end
   endtask

   task automatic test_full_wrap();
      logic [31:0] seq [$];
      for (int i = 0; i < 4; i++) begin
         step(0, 1'b1, 1'b0, 1'b0, 32'hB000 + i);
         seq.push_back(32'hB000 + i);
      end
      n_checks++; if (cnt_o[0] !== 4'd4 || rdy_o[0] !== 1'b0) begin
         n_errors++; $display("FAIL full_state: got cnt %0d rdy %b want cnt 4 rdy 0", cnt_o[0], rdy_o[0]);
      end
      adv_v[0] = 1'b1;
      #1;
      n_checks++; if (rdy_o[0] !== 1'b1) begin n_errors++; $display("FAIL full_rdy_adv: got %b want 1", rdy_o[0]); end
      adv_v[0] = 1'b0;
      step(0, 1'b1, 1'b0, 1'b0, 32'hBEEF);
      n_checks++; if (cnt_o[0] !== 4'd4 || ins_o[0] !== 32'hB000) begin
         n_errors++; $display("FAIL full_drop: got cnt %0d head %h want cnt 4 head b000", cnt_o[0], ins_o[0]);
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 1'b1, 1'b1, 1'b0, 32'hC000 + i);
         seq.push_back(32'hC000 + i);
         void'(seq.pop_front());
         n_checks++; if (cnt_o[0] !== 4'd4 || ins_o[0] !== seq[0]) begin
            n_errors++; $display("FAIL wrap_%0d: got cnt %0d head %h want cnt 4 head %h", i, cnt_o[0], ins_o[0], seq[0]);
         end
      end
   endtask

   task automatic test_simul_count1();
      step(0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(0, 1'b1, 1'b0, 1'b0, 32'hD001);
      n_checks++; if (cnt_o[0] !== 4'd1 || ins_o[0] !== 32'hD001) begin
         n_errors++; $display("FAIL c1_setup: got cnt %0d head %h want cnt 1 head d001", cnt_o[0], ins_o[0]);
      end
      step(0, 1'b1, 1'b1, 1'b0, 32'hD002);
      n_checks++; if (cnt_o[0] !== 4'd1 || ins_o[0] !== 32'hD002 || vld_o[0] !== 1'b1) begin
         n_errors++; $display("FAIL c1_pushpop: got cnt %0d head %h vld %b want cnt 1 head d002 vld 1", cnt_o[0], ins_o[0], vld_o[0]);
      end
      // After a flush ins_out exposes the hold register.
      step(0, 1'b0, 1'b0, 1'b1, 32'h0);
      n_checks++; if (ins_o[0] !== 32'hD001 || vld_o[0] !== 1'b0) begin
         n_errors++; $display("FAIL c1_last: got %h vld %b want d001 vld 0", ins_o[0], vld_o[0]);
      end
   endtask

   task automatic test_flush_priority();
      step(0, 1'b1, 1'b0, 1'b0, 32'hE000);
      step(0, 1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 1; i <= 3; i++) step(0, 1'b1, 1'b0, 1'b0, 32'hE000 + i);
      n_checks++; if (cnt_o[0] !== 4'd3 || ins_o[0] !== 32'hE001) begin
         n_errors++; $display("FAIL flush_setup: got cnt %0d head %h want cnt 3 head e001", cnt_o[0], ins_o[0]);
      end
      step(0, 1'b1, 1'b1, 1'b1, 32'hE0FF);
      n_checks++; if (cnt_o[0] !== 4'd0 || vld_o[0] !== 1'b0 || ins_o[0] !== 32'hE000) begin
         n_errors++; $display("FAIL flush_prio: got cnt %0d vld %b ins %h want cnt 0 vld 0 ins e000", cnt_o[0], vld_o[0], ins_o[0]);
      end
      step(0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++; if (cnt_o[0] !== 4'd0 || ins_o[0] !== 32'hE000) begin
         n_errors++; $display("FAIL flush_noqueue: got cnt %0d ins %h want cnt 0 ins e000", cnt_o[0], ins_o[0]);
      end
   endtask

   task automatic test_random_sweep(input int k, input int depth, input int width, input int n);
      logic [31:0] q [$];
      logic [31:0] last_w;
      logic [31:0] mask;
      logic [31:0] exp_ins;
      logic [3:0]  exp_cnt;
      logic        exp_vld;
      logic        exp_rdy;
      logic        il, adv, fl;
      logic        pop, push;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_w = 32'h0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         il  = ($urandom_range(0, 9) < 6);
         adv = ($urandom_range(0, 9) < 5);
         fl  = ($urandom_range(0, 19) == 0);
         il_v[k] = il; adv_v[k] = adv; flush_v[k] = fl; din_v[k] = $urandom & mask;
         #1;
         exp_vld = (q.size() > 0);
         exp_cnt = 4'(q.size());
         exp_ins = (q.size() > 0) ? q[0] : last_w;
         exp_rdy = (q.size() < depth) || (adv && q.size() > 0);
         n_checks++; if (ins_o[k] !== exp_ins) begin n_errors++; $display("FAIL rnd%0d_ins cyc %0d: got %h want %h", k, i, ins_o[k], exp_ins); end
         n_checks++; if (vld_o[k] !== exp_vld) begin n_errors++; $display("FAIL rnd%0d_vld cyc %0d: got %b want %b", k, i, vld_o[k], exp_vld); end
         n_checks++; if (cnt_o[k] !== exp_cnt) begin n_errors++; $display("FAIL rnd%0d_cnt cyc %0d: got %0d want %0d", k, i, cnt_o[k], exp_cnt); end
         n_checks++; if (rdy_o[k] !== exp_rdy) begin n_errors++; $display("FAIL rnd%0d_rdy cyc %0d: got %b want %b", k, i, rdy_o[k], exp_rdy); end
         if (fl) begin
            q.delete();
         end else begin
            pop  = adv && (q.size() > 0);
            push = il && ((q.size() < depth) || pop);
            if (pop)  last_w = q.pop_front();
            if (push) q.push_back(din_v[k]);
         end
      end
      @(negedge clk);
      il_v[k] = 1'b0; adv_v[k] = 1'b0; flush_v[k] = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         il_v[i] = 1'b0; adv_v[i] = 1'b0; flush_v[i] = 1'b0; din_v[i] = 32'h0;
      end
      test_reset();
      test_fifo_order();
      test_full_wrap();
      test_simul_count1();
      test_flush_priority();
      test_random_sweep(0, 4, 16, 300);
      test_random_sweep(1, 2, 8, 400);
      test_random_sweep(2, 8, 32, 400);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ir_queue
